// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the push-button conditioning block.
package key_debounce_pkg;

    // Per-channel hold-tracking state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } key_state_e;

    // Default timing for a 50 MHz clock.
    localparam int unsigned DEF_DB_CYCLES     = 500_000;     // 10 ms
    localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;  // 200 ms

endpackage : key_debounce_pkg

// File: rtl/key_debounce_ch.sv
// One button channel: 2-FF synchroniser, counter debounce, press/hold FSM
// and single-cycle event pulses.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
    localparam int unsigned RPT_W  = $clog2(REPEAT_CYCLES);

    // Raw pin level while the button is not pressed.
    localparam logic REL_LVL = ACTIVE_LOW;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              norm;
    logic              accept;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              pressed_q, pressed_d;
    key_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              long_pulse_q, long_pulse_d;
    logic              repeat_pulse_q, repeat_pulse_d;

    // Next-state logic: synchroniser shift, debounce counter and hold FSM.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        sync1_d         = key_raw;
        sync2_d         = sync1_q;
        norm            = sync2_q ^ ACTIVE_LOW;
        accept          = 1'b0;
        db_cnt_d        = db_cnt_q;
        pressed_d       = pressed_q;
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        rpt_cnt_d       = rpt_cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        repeat_pulse_d  = 1'b0;

        // Count consecutive cycles where the synchronised level disagrees
        // with the accepted level; any agreement restarts the count.
        if (norm == pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            accept    = 1'b1;
            pressed_d = norm;
            db_cnt_d  = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        // The FSM is IDLE exactly when pressed_q is 0, so an acceptance in
        // IDLE is a press and one in PRESSED/HELD is a release. A release
        // takes priority over a coincident long/repeat terminal count.
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    press_pulse_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (accept) begin
                    release_pulse_d = 1'b1;
                    state_d         = ST_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    long_pulse_d = 1'b1;
                    rpt_cnt_d    = '0;
                    state_d      = ST_HELD;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (accept) begin
                    release_pulse_d = 1'b1;
                    state_d         = ST_IDLE;
                end else if (rpt_cnt_q == RPT_LAST) begin
                    repeat_pulse_d = 1'b1;
                    rpt_cnt_d      = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset to the released condition.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            sync1_q         <= REL_LVL;
            sync2_q         <= REL_LVL;
            db_cnt_q        <= '0;
            pressed_q       <= 1'b0;
            state_q         <= ST_IDLE;
            hold_cnt_q      <= '0;
            rpt_cnt_q       <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            repeat_pulse_q  <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            db_cnt_q        <= db_cnt_d;
            pressed_q       <= pressed_d;
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            rpt_cnt_q       <= rpt_cnt_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            repeat_pulse_q  <= repeat_pulse_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign repeat_pulse  = repeat_pulse_q;

endmodule : key_debounce_ch

// File: rtl/key_debounce_events.sv
// Push-button conditioning between the KEY pins and the push_button PIO:
// N_CH independent debounce channels plus the raw-polarity level for the PIO.
module key_debounce_events
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_CH          = 1,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] key_raw,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] pressed_pio,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_raw       (key_raw[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    // The PIO sees the debounced level in the pin's own polarity.
    assign pressed_pio = pressed ^ {N_CH{ACTIVE_LOW}};

endmodule : key_debounce_events

// File: tb/tb_key_debounce_events.sv
// Bench for key_debounce_events: table of per-channel press patterns with
// hand-derived event times, plus hand-written bounce and reset-mid-hold
// sequences. Expected events go into a scoreboard keyed by cycle number and
// are compared against the DUT outputs on every falling edge.
module tb_key_debounce_events;

    localparam int N_CH   = 2;
    localparam int REPEAT = 8;

    typedef enum int {K_PRESS, K_RELEASE, K_LONG, K_REPEAT} kind_e;

    typedef struct {
        int    cyc;
        int    ch;
        kind_e kind;
    } ev_t;

    // Per-channel stimulus and expectations, offsets relative to the cycle
    // the key goes low; -1 means the event must not occur.
    typedef struct {
        int len;
        int press_ofs;
        int rel_ofs;
        int long_ofs;
        int n_rpt;
    } ch_exp_t;

    typedef struct {
        ch_exp_t c0;
        ch_exp_t c1;
    } vec_t;

    logic            clk;
    logic            reset_n;
    logic [N_CH-1:0] key_raw;
    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] pressed_pio;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] repeat_pulse;

    int              cyc;
    int              checks;
    int              failures;
    bit              mon_en;
    bit              rst_at_edge;
    logic [N_CH-1:0] exp_pressed;
    logic [N_CH-1:0] e_pr, e_rl, e_lg, e_rp;
    ev_t             sb_q[$];
    vec_t            vecs[9];

    key_debounce_events #(
        .N_CH          (N_CH),
        .ACTIVE_LOW    (1'b1),
        .DB_CYCLES     (4),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_raw       (key_raw),
        .pressed       (pressed),
        .pressed_pio   (pressed_pio),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !reset_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input int ch, input kind_e k);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = k;
        sb_q.push_back(e);
    endtask

    function automatic ch_exp_t mk(input int len, input int p, input int r, input int l, input int n);
        ch_exp_t e;
        e.len       = len;
        e.press_ofs = p;
        e.rel_ofs   = r;
        e.long_ofs  = l;
        e.n_rpt     = n;
        return e;
    endfunction

    task automatic schedule(input int t0, input int ch, input ch_exp_t e);
        if (e.press_ofs >= 0) push_ev(t0 + e.press_ofs, ch, K_PRESS);
        if (e.rel_ofs >= 0)   push_ev(t0 + e.rel_ofs, ch, K_RELEASE);
        if (e.long_ofs >= 0)  push_ev(t0 + e.long_ofs, ch, K_LONG);
        for (int r = 1; r <= e.n_rpt; r++)
            push_ev(t0 + e.long_ofs + REPEAT * r, ch, K_REPEAT);
    endtask

    task automatic apply_vec(input vec_t v);
        ch_exp_t e[2];
        int      t0;
        int      maxlen;
        e[0]   = v.c0;
        e[1]   = v.c1;
        t0     = cyc;
        maxlen = 0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (e[ch].len > 0) begin
                key_raw[ch] = 1'b0;
                schedule(t0, ch, e[ch]);
                if (e[ch].len > maxlen) maxlen = e[ch].len;
            end
        end
        for (int k = 1; k <= maxlen; k++) begin
            tick(1);
            for (int ch = 0; ch < N_CH; ch++)
                if (e[ch].len == k) key_raw[ch] = 1'b1;
        end
        tick(12);
    endtask

    // Scoreboard monitor: compare pulses and levels every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_at_edge) exp_pressed = '0;
            e_pr = '0;
            e_rl = '0;
            e_lg = '0;
            e_rp = '0;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc == cyc) begin
                    case (sb_q[i].kind)
                        K_PRESS:   begin e_pr[sb_q[i].ch] = 1'b1; exp_pressed[sb_q[i].ch] = 1'b1; end
                        K_RELEASE: begin e_rl[sb_q[i].ch] = 1'b1; exp_pressed[sb_q[i].ch] = 1'b0; end
                        K_LONG:    e_lg[sb_q[i].ch] = 1'b1;
                        default:   e_rp[sb_q[i].ch] = 1'b1;
                    endcase
                    sb_q.delete(i);
                end
            end
            check("pulses{press,rel,long,rpt}",
                  {24'd0, press_pulse, release_pulse, long_pulse, repeat_pulse},
                  {24'd0, e_pr, e_rl, e_lg, e_rp});
            check("pressed", {30'd0, pressed}, {30'd0, exp_pressed});
            check("pressed_pio", {30'd0, pressed_pio}, {30'd0, ~exp_pressed});
        end
    end

    initial begin
        int t0;
        ch_exp_t none_c;

        cyc         = 0;
        checks      = 0;
        failures    = 0;
        mon_en      = 1'b0;
        exp_pressed = '0;
        reset_n     = 1'b0;
        key_raw     = '1;

        none_c = mk(0, -1, -1, -1, 0);
        vecs[0].c0 = mk(3, -1, -1, -1, 0);  vecs[0].c1 = none_c;                  // glitch ch0
        vecs[1].c0 = none_c;                vecs[1].c1 = mk(1, -1, -1, -1, 0);    // glitch ch1
        vecs[2].c0 = mk(4, 6, 10, -1, 0);   vecs[2].c1 = none_c;                  // shortest accepted
        vecs[3].c0 = none_c;                vecs[3].c1 = mk(10, 6, 16, -1, 0);
        vecs[4].c0 = mk(20, 6, 26, -1, 0);  vecs[4].c1 = none_c;                  // release wins over long
        vecs[5].c0 = mk(21, 6, 27, 26, 0);  vecs[5].c1 = none_c;                  // long just before release
        vecs[6].c0 = mk(60, 6, 66, 26, 4);  vecs[6].c1 = none_c;                  // release wins over repeat
        vecs[7].c0 = mk(30, 6, 36, 26, 1);  vecs[7].c1 = mk(8, 6, 14, -1, 0);     // ch1 early release
        vecs[8].c0 = mk(12, 6, 18, -1, 0);  vecs[8].c1 = mk(12, 6, 18, -1, 0);    // simultaneous

        // Reset state is checked by the monitor while reset is held.
        tick(1);
        mon_en = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(4);

        for (int v = 0; v < 9; v++) apply_vec(vecs[v]);

        // Bounce on ch0: low 3, high 1, then steady low; one press 10 cycles after the first fall.
        t0 = cyc;
        key_raw[0] = 1'b0;
        push_ev(t0 + 10, 0, K_PRESS);
        push_ev(t0 + 20, 0, K_RELEASE);
        tick(3);  key_raw[0] = 1'b1;
        tick(1);  key_raw[0] = 1'b0;
        tick(10); key_raw[0] = 1'b1;
        tick(12);

        // Reset mid-hold in HELD, key still held afterwards: fresh press 6 cycles after release of reset.
        t0 = cyc;
        key_raw[0] = 1'b0;
        push_ev(t0 + 6, 0, K_PRESS);
        push_ev(t0 + 26, 0, K_LONG);
        push_ev(t0 + 34, 0, K_REPEAT);
        push_ev(t0 + 42, 0, K_REPEAT);
        tick(45);
        reset_n = 1'b0;
        tick(1);
        sb_q.delete();
        tick(2);
        reset_n = 1'b1;
        t0 = cyc;
        push_ev(t0 + 6, 0, K_PRESS);
        push_ev(t0 + 18, 0, K_RELEASE);
        tick(12); key_raw[0] = 1'b1;
        tick(12);

        mon_en = 1'b0;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_key_debounce_events
